// File: rtl/nn_layer_sequencer.sv
// Layer/neuron sequencer for the CORDIC NN engine: drives MAC and activation handshakes.
// Define NN_SEQ_PERF_EN to add the perf_cycles / perf_stall counter outputs.
module nn_layer_sequencer #(
    parameter int WA_W       = 12,
    parameter int MAX_LAYERS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      n_in,
    input  logic [5:0]      no_layers,
    input  logic [5:0]      nl1,
    input  logic [5:0]      nl2,
    input  logic [5:0]      nl3,
    input  logic [5:0]      nl4,
    input  logic [5:0]      nl5,
    input  logic [1:0]      afl1,
    input  logic [1:0]      afl2,
    input  logic [1:0]      afl3,
    input  logic [1:0]      afl4,
    input  logic [1:0]      afl5,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            acc_clr,
    output logic            mac_req,
    input  logic            mac_ack,
    output logic [WA_W-1:0] w_addr,
    output logic [5:0]      x_addr,
    output logic            x_bank,
    output logic            act_req,
    output logic [1:0]      act_fn,
    input  logic            act_ack,
    output logic            y_we,
    output logic [5:0]      y_addr,
    output logic            y_bank,
    output logic [2:0]      layer_idx,
    output logic            result_bank
`ifdef NN_SEQ_PERF_EN
    ,
    output logic [15:0]     perf_cycles,
    output logic [15:0]     perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_MAC, S_ACT, S_WR, S_DONE
    } state_t;

    state_t state, state_nxt;

    // Entry 0 holds n_in so that fan-in of layer L is simply nl_q[L-1].
    logic [5:0] nl_q  [8];
    logic [1:0] afl_q [8];
    logic [5:0] no_layers_q;
    logic [2:0] layer;
    logic [5:0] neuron;
    logic [5:0] fan_in;
    logic [5:0] layer_size;
    logic       cfg_bad;
    logic       last_in;
    logic       last_neuron;
    logic       more_layers;

    assign fan_in      = nl_q[layer - 3'd1];
    assign layer_size  = nl_q[layer];
    assign last_in     = (x_addr == fan_in - 6'd1);
    assign last_neuron = (neuron == layer_size - 6'd1);
    assign more_layers = ({3'b000, layer} < no_layers_q);
    assign layer_idx   = (state == S_IDLE) ? 3'd0 : layer;
    assign y_addr      = neuron;

    always_comb begin
        cfg_bad = (no_layers_q == '0) || (no_layers_q > 6'(MAX_LAYERS)) || (nl_q[0] == '0);
        for (int unsigned i = 1; i < 6; i++) begin
            if ((6'(i) <= no_layers_q) && (nl_q[i] == '0)) cfg_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        acc_clr   = 1'b0;
        mac_req   = 1'b0;
        act_req   = 1'b0;
        y_we      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = cfg_bad ? S_DONE : S_CLR;
            S_CLR: begin
                acc_clr   = 1'b1;
                state_nxt = S_MAC;
            end
            S_MAC: begin
                mac_req = 1'b1;
                if (mac_ack && last_in) state_nxt = S_ACT;
            end
            S_ACT: begin
                act_req = 1'b1;
                if (act_ack) state_nxt = S_WR;
            end
            S_WR: begin
                y_we = 1'b1;
                if (!last_neuron)     state_nxt = S_CLR;
                else if (more_layers) state_nxt = S_LOAD;
                else                  state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                nl_q[i]  <= '0;
                afl_q[i] <= '0;
            end
            no_layers_q <= '0;
            layer       <= '0;
            neuron      <= '0;
            err         <= 1'b0;
            w_addr      <= '0;
            x_addr      <= '0;
            x_bank      <= 1'b0;
            y_bank      <= 1'b0;
            act_fn      <= '0;
            result_bank <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    nl_q[0]     <= n_in;
                    nl_q[1]     <= nl1;
                    nl_q[2]     <= nl2;
                    nl_q[3]     <= nl3;
                    nl_q[4]     <= nl4;
                    nl_q[5]     <= nl5;
                    nl_q[6]     <= '0;
                    nl_q[7]     <= '0;
                    afl_q[0]    <= '0;
                    afl_q[1]    <= afl1;
                    afl_q[2]    <= afl2;
                    afl_q[3]    <= afl3;
                    afl_q[4]    <= afl4;
                    afl_q[5]    <= afl5;
                    afl_q[6]    <= '0;
                    afl_q[7]    <= '0;
                    no_layers_q <= no_layers;
                    err         <= 1'b0;
                    w_addr      <= '0;
                    layer       <= 3'd1;
                end
                S_LOAD: begin
                    if (cfg_bad) err <= 1'b1;
                    // Odd layers read bank 0 and write bank 1; even layers the reverse.
                    x_bank <= ~layer[0];
                    y_bank <= layer[0];
                    neuron <= '0;
                    act_fn <= afl_q[layer];
                end
                S_MAC: if (mac_ack) begin
                    w_addr <= w_addr + 1'b1;
                    x_addr <= x_addr + 1'b1;
                end
                S_WR: begin
                    if (!last_neuron)     neuron <= neuron + 6'd1;
                    else if (more_layers) layer  <= layer + 3'd1;
                end
                S_DONE: result_bank <= y_bank;
                default: ;
            endcase
            if (state_nxt == S_CLR) x_addr <= '0;
        end
    end

`ifdef NN_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 16'd1;
            if (((mac_req && !mac_ack) || (act_req && !act_ack)) && (perf_stall != '1))
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: a network-level model queues expected
// MAC transfers, result writes and completions; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_nn_layer_sequencer;
    localparam int WA_W = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, start;
    logic [5:0]      n_in, no_layers, nl1, nl2, nl3, nl4, nl5;
    logic [1:0]      afl1, afl2, afl3, afl4, afl5;
    logic            busy, done, err, acc_clr, mac_req, mac_ack;
    logic [WA_W-1:0] w_addr;
    logic [5:0]      x_addr, y_addr;
    logic            x_bank, act_req, act_ack, y_we, y_bank, result_bank;
    logic [1:0]      act_fn;
    logic [2:0]      layer_idx;
`ifdef NN_SEQ_PERF_EN
    logic [15:0]     perf_cycles, perf_stall;
`endif

    nn_layer_sequencer #(.WA_W(WA_W), .MAX_LAYERS(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .no_layers(no_layers),
        .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
        .afl1(afl1), .afl2(afl2), .afl3(afl3), .afl4(afl4), .afl5(afl5),
        .busy(busy), .done(done), .err(err), .acc_clr(acc_clr),
        .mac_req(mac_req), .mac_ack(mac_ack), .w_addr(w_addr), .x_addr(x_addr),
        .x_bank(x_bank), .act_req(act_req), .act_fn(act_fn), .act_ack(act_ack),
        .y_we(y_we), .y_addr(y_addr), .y_bank(y_bank), .layer_idx(layer_idx),
        .result_bank(result_bank)
`ifdef NN_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [5:0] nl [6];   // nl[0] is n_in
        logic [5:0] nlayers;
        logic [1:0] afl [6];
    } cfg_t;

    typedef struct {
        logic            err;
        bit              chk_rb;
        logic            rb;
        logic [WA_W-1:0] wa;
        int unsigned     base;
        int unsigned     n_neur;
    } done_t;

    logic [21:0] mac_q [$];
    logic [11:0] wr_q  [$];
    done_t       done_q [$];

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned mac_dmin = 0, mac_dmax = 0, act_dmin = 0, act_dmax = 0;
    bit          ack_noise = 1'b0;
    int unsigned stall_acc = 0, mac_wait = 0, act_wait = 0;
    int unsigned busy_cnt, clr_cnt, act_cnt, stall_mark;
    bit          pend;
    done_t       pend_d;
    int unsigned pend_stall;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, err, acc_clr, mac_req, w_addr, x_addr, x_bank, act_req,
                    act_fn, y_we, y_addr, y_bank, layer_idx, result_bank});
    endfunction

    // Network-level reference: enumerate every neuron/input in order.
    task automatic model_push(input cfg_t c);
        int unsigned wa, nclr, base, fan;
        bit          bad;
        logic        xb;
        done_t       d;
        wa = 0; nclr = 0; xb = 1'b0;
        bad = (c.nlayers == 6'd0) || (c.nlayers > 6'd5) || (c.nl[0] == 6'd0);
        for (int l = 1; l <= 5; l++)
            if ((l <= int'(c.nlayers)) && (c.nl[l] == 6'd0)) bad = 1'b1;
        d.err = bad; d.chk_rb = !bad; d.rb = 1'b0; d.wa = '0; d.base = 2; d.n_neur = 0;
        if (!bad) begin
            base = 1;
            for (int l = 1; l <= int'(c.nlayers); l++) begin
                fan  = int'(c.nl[l-1]);
                xb   = ((l % 2) == 0);
                base += 1 + int'(c.nl[l]) * (fan + 3);
                for (int n = 0; n < int'(c.nl[l]); n++) begin
                    for (int i = 0; i < int'(fan); i++) begin
                        mac_q.push_back({WA_W'(wa), 6'(i), xb, 3'(l)});
                        wa++;
                    end
                    wr_q.push_back({6'(n), ~xb, c.afl[l], 3'(l)});
                    nclr++;
                end
            end
            d.rb = ~xb; d.wa = WA_W'(wa); d.base = base; d.n_neur = nclr;
        end
        done_q.push_back(d);
    endtask

    task automatic apply(input cfg_t c);
        n_in = c.nl[0]; no_layers = c.nlayers;
        nl1 = c.nl[1]; nl2 = c.nl[2]; nl3 = c.nl[3]; nl4 = c.nl[4]; nl5 = c.nl[5];
        afl1 = c.afl[1]; afl2 = c.afl[2]; afl3 = c.afl[3]; afl4 = c.afl[4]; afl5 = c.afl[5];
    endtask

    task automatic scramble();
        n_in = 6'($urandom); no_layers = 6'($urandom);
        nl1 = 6'($urandom); nl2 = 6'($urandom); nl3 = 6'($urandom);
        nl4 = 6'($urandom); nl5 = 6'($urandom);
        afl1 = 2'($urandom); afl2 = 2'($urandom); afl3 = 2'($urandom);
        afl4 = 2'($urandom); afl5 = 2'($urandom);
    endtask

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.nlayers = 6'd3;
        c.nl[0] = 6'd4; c.nl[1] = 6'd4; c.nl[2] = 6'd2; c.nl[3] = 6'd3; c.nl[4] = 6'd0; c.nl[5] = 6'd0;
        c.afl[0] = 2'd0; c.afl[1] = 2'd1; c.afl[2] = 2'd2; c.afl[3] = 2'd3; c.afl[4] = 2'd0; c.afl[5] = 2'd1;
        return c;
    endfunction

    function automatic cfg_t rand_cfg(input bit allow_bad);
        cfg_t c;
        c.nlayers = 6'($urandom_range(5, 1));
        c.nl[0]   = 6'($urandom_range(6, 1));
        c.afl[0]  = 2'd0;
        for (int l = 1; l <= 5; l++) begin
            c.nl[l]  = (l <= int'(c.nlayers)) ? 6'($urandom_range(6, 1)) : 6'($urandom_range(6, 0));
            c.afl[l] = 2'($urandom);
        end
        if (allow_bad && ($urandom_range(3, 0) == 0)) begin
            case ($urandom_range(3, 0))
                0: c.nlayers = 6'd0;
                1: c.nlayers = 6'($urandom_range(63, 6));
                2: c.nl[$urandom_range(int'(c.nlayers), 1)] = 6'd0;
                default: c.nl[0] = 6'd0;
            endcase
        end
        return c;
    endfunction

    task automatic do_run(input cfg_t c, input bit perturb);
        @(posedge clk); #1;
        apply(c);
        model_push(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            if (perturb) begin
                start = 1'($urandom);
                scramble();
            end
            @(posedge clk); #1;
        end
        chk("done_reached", 64'(done), 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    // Handshake responder: chosen wait cycles on each request, optional stray acks when idle.
    initial begin
        mac_ack = 1'b0;
        act_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mac_req) begin
                if (mac_wait == 0) begin
                    mac_ack  = 1'b1;
                    mac_wait = $urandom_range(mac_dmax, mac_dmin);
                end else begin
                    mac_ack = 1'b0;
                    mac_wait--;
                    stall_acc++;
                end
            end else begin
                mac_ack  = ack_noise ? 1'($urandom) : 1'b0;
                mac_wait = $urandom_range(mac_dmax, mac_dmin);
            end
            if (act_req) begin
                if (act_wait == 0) begin
                    act_ack  = 1'b1;
                    act_wait = $urandom_range(act_dmax, act_dmin);
                end else begin
                    act_ack = 1'b0;
                    act_wait--;
                    stall_acc++;
                end
            end else begin
                act_ack  = ack_noise ? 1'($urandom) : 1'b0;
                act_wait = $urandom_range(act_dmax, act_dmin);
            end
        end
    end

    initial begin
        done_t d;
        busy_cnt = 0; clr_cnt = 0; act_cnt = 0; stall_mark = 0; pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mac_q.delete(); wr_q.delete(); done_q.delete();
                busy_cnt = 0; clr_cnt = 0; act_cnt = 0; stall_mark = stall_acc; pend = 1'b0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    chk("idle_after_done", 64'(busy), 64'd0);
                    chk("err_hold", 64'(err), 64'(pend_d.err));
                    if (pend_d.chk_rb) chk("result_bank", 64'(result_bank), 64'(pend_d.rb));
`ifdef NN_SEQ_PERF_EN
                    chk("perf_cycles", 64'(perf_cycles), 64'(pend_d.base + pend_stall));
                    chk("perf_stall", 64'(perf_stall), 64'(pend_stall));
`endif
                end
                if (busy)              busy_cnt++;
                if (acc_clr)           clr_cnt++;
                if (act_req && act_ack) act_cnt++;
                if (mac_req && mac_ack) begin
                    if (mac_q.size() == 0) chk("mac_extra", 64'({mac_req, mac_ack}), 64'd0);
                    else chk("mac_xfer", 64'({w_addr, x_addr, x_bank, layer_idx}), 64'(mac_q.pop_front()));
                end
                if (y_we) begin
                    if (wr_q.size() == 0) chk("wr_extra", 64'(y_we), 64'd0);
                    else chk("y_write", 64'({y_addr, y_bank, act_fn, layer_idx}), 64'(wr_q.pop_front()));
                end
                if (done) begin
                    if (done_q.size() == 0) chk("done_extra", 64'(done), 64'd0);
                    else begin
                        d = done_q.pop_front();
                        chk("done_err", 64'(err), 64'(d.err));
                        chk("done_w_addr", 64'(w_addr), 64'(d.wa));
                        chk("busy_cycles", 64'(busy_cnt), 64'(d.base + (stall_acc - stall_mark)));
                        chk("acc_clr_count", 64'(clr_cnt), 64'(d.n_neur));
                        chk("act_count", 64'(act_cnt), 64'(d.n_neur));
                        chk("queues_drained", 64'(mac_q.size() + wr_q.size()), 64'd0);
                        pend = 1'b1; pend_d = d; pend_stall = stall_acc - stall_mark;
                    end
                    stall_mark = stall_acc;
                    busy_cnt = 0; clr_cnt = 0; act_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cfg_t c;
        rst_n = 1'b0; start = 1'b0;
        apply(base_cfg());
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 64'd0);
`ifdef NN_SEQ_PERF_EN
        chk("reset_perf", 64'({perf_cycles, perf_stall}), 64'd0);
`endif
        rst_n = 1'b1;

        c = base_cfg();
        do_run(c, 1'b0);
        mac_dmin = 3; mac_dmax = 3;
        do_run(c, 1'b0);
        mac_dmin = 0; mac_dmax = 0;

        c = base_cfg(); c.nlayers = 6'd0; do_run(c, 1'b0);
        c.nlayers = 6'd6;                 do_run(c, 1'b0);
        c = base_cfg(); c.nl[2] = 6'd0;   do_run(c, 1'b0);
        c = base_cfg(); c.nl[0] = 6'd0;   do_run(c, 1'b0);
        do_run(base_cfg(), 1'b0);

        ack_noise = 1'b1;
        do_run(base_cfg(), 1'b1);

        c = base_cfg(); c.nlayers = 6'd2; c.nl[0] = 6'd3; c.nl[1] = 6'd2; c.nl[2] = 6'd3;
        do_run(c, 1'b0);

        c = base_cfg(); mac_dmax = 2; act_dmax = 2;
        @(posedge clk); #1;
        apply(c); model_push(c); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !(layer_idx == 3'd2 && mac_req && x_addr == 6'd2); cyc++) begin
            @(posedge clk); #1;
        end
        chk("abort_point", 64'({layer_idx, mac_req}), 64'({3'd2, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_run(c, 1'b0);

        mac_dmax = 0; act_dmax = 0; ack_noise = 1'b0;
        c.nlayers = 6'd2; c.nl[0] = 6'd63; c.nl[1] = 6'd63; c.nl[2] = 6'd63;
        do_run(c, 1'b0);

        for (int r = 0; r < 20; r++) begin
            mac_dmax  = $urandom_range(2, 0);
            act_dmax  = $urandom_range(2, 0);
            ack_noise = 1'($urandom);
            do_run(rand_cfg(1'b1), 1'($urandom));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
